dm_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters.
- Requester P is the pipeline MEM stage; requester E is the external loader/debug port.
- P has fixed priority. E gets a guaranteed grant through a starvation counter and can hold the port for bounded locked bursts.
- The block sits between the MEM stage/loader and the DM, and checks address range and alignment before any write reaches the memory.

---
 rtl/dm_pkg.sv | 18 +
 rtl/dm_legal_chk.sv | 26 ++
 rtl/dm_arbiter.sv | 153 +++++++++++++++
 tb/tb_dm_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter: DM access modes and
// the size of the data memory behind the shared port.
package dm_pkg;

  // DM access modes as seen on the DMMode input of the memory.
  typedef enum logic [3:0] {
    DM_W  = 4'd0,  // word
    DM_B  = 4'd1,  // byte, sign-extended
    DM_H  = 4'd2,  // half, sign-extended
    DM_BU = 4'd3,  // byte, zero-extended
    DM_HU = 4'd4   // half, zero-extended
  } dm_mode_e;

  localparam int unsigned DM_WORDS      = 3072;
  localparam logic [31:0] DM_ADDR_LIMIT = 32'(DM_WORDS * 4);
  localparam logic [31:0] DM_EXT_PC     = 32'hFFFF_FFFC;

endpackage

// File: rtl/dm_legal_chk.sv
// Combinational legality check for one requester's DM access: range,
// mode encoding, store width and natural alignment.
module dm_legal_chk
  import dm_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = DM_ADDR_LIMIT
) (
  input  logic [3:0]  mode_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  output logic        legal_o
);

  // Start from legal and knock out each illegal case.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    legal_o = 1'b1;
    if (addr_i >= ADDR_LIMIT)                             legal_o = 1'b0;
    if (mode_i > 4'(DM_HU))                               legal_o = 1'b0;
    // Stores only exist as word, byte and half; the unsigned modes are load-only.
    if (we_i && (mode_i > 4'(DM_H)))                      legal_o = 1'b0;
    if ((mode_i == DM_W) && (addr_i[1:0] != 2'b00))       legal_o = 1'b0;
    if (((mode_i == DM_H) || (mode_i == DM_HU)) && addr_i[0]) legal_o = 1'b0;
  end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single data-memory port between the pipeline MEM stage (P,
// fixed priority) and the external loader/debug port (E). E is protected
// against starvation by a wait counter and may hold the port for bounded
// locked bursts. Illegal accesses are consumed without writing the DM.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned WAIT_MAX   = 4,
  parameter int unsigned LOCK_MAX   = 8,
  parameter logic [31:0] ADDR_LIMIT = DM_ADDR_LIMIT,
  parameter logic [31:0] EXT_PC     = DM_EXT_PC
) (
  input  logic        clk,
  input  logic        reset,
  // pipeline MEM stage
  input  logic        p_req,
  input  logic        p_we,
  input  logic [3:0]  p_mode,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  input  logic [31:0] p_pc,
  output logic [31:0] p_rdata,
  output logic        p_stall,
  output logic        p_err,
  // external loader / debug port
  input  logic        e_req,
  input  logic        e_we,
  input  logic [3:0]  e_mode,
  input  logic [31:0] e_addr,
  input  logic [31:0] e_wdata,
  input  logic        e_lock,
  output logic        e_gnt,
  output logic        e_rvalid,
  output logic [31:0] e_rdata,
  output logic        e_err,
  // data memory
  output logic        dm_we,
  output logic [3:0]  dm_mode,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rdata
);

  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);

  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          lock_q, lock_d;
  logic          e_rvalid_q, e_rvalid_d;
  logic          e_err_q, e_err_d;
  logic [31:0]   e_rdata_q, e_rdata_d;

  logic legal_p, legal_e;
  logic starve, lock_ok, own_e, own_p;

  dm_legal_chk #(.ADDR_LIMIT(ADDR_LIMIT)) u_chk_p (
    .mode_i (p_mode),
    .we_i   (p_we),
    .addr_i (p_addr),
    .legal_o(legal_p)
  );

  dm_legal_chk #(.ADDR_LIMIT(ADDR_LIMIT)) u_chk_e (
    .mode_i (e_mode),
    .we_i   (e_we),
    .addr_i (e_addr),
    .legal_o(legal_e)
  );

  // Ownership: P wins ties unless E is starved or inside an unexpired lock.
  always_comb begin
    starve  = (wait_cnt_q == WW'(WAIT_MAX));
    lock_ok = lock_q && (lock_cnt_q < LW'(LOCK_MAX));
    own_e   = !reset && e_req && (!p_req || starve || lock_ok);
    own_p   = !reset && p_req && !own_e;
  end

  // Handshakes and the DM port mux; writes are gated by legality of the owner.
  always_comb begin
    e_gnt   = own_e;
    p_stall = p_req && own_e;
    p_err   = own_p && !legal_p;
    p_rdata = dm_rdata;
    dm_we   = (own_e && e_we && legal_e) || (own_p && p_we && legal_p);
    if (own_e) begin
      dm_mode  = e_mode;
      dm_addr  = e_addr;
      dm_wdata = e_wdata;
      dm_pc    = EXT_PC;
    end else begin
      dm_mode  = p_mode;
      dm_addr  = p_addr;
      dm_wdata = p_wdata;
      dm_pc    = p_pc;
    end
  end

  // Next state of the starvation/lock counters and the E response.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    lock_cnt_d = lock_cnt_q;
    lock_d     = lock_q;

    if (own_e || !e_req) begin
      wait_cnt_d = '0;
    end else if (!starve) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    if (own_e) begin
      lock_d = e_lock;
      if (lock_cnt_q != LW'(LOCK_MAX)) lock_cnt_d = lock_cnt_q + 1'b1;
    end else if (!e_req) begin
      lock_d     = 1'b0;
      lock_cnt_d = '0;
    end else if ((lock_cnt_q == LW'(LOCK_MAX)) && p_req) begin
      // P has taken its one cycle; the lock survives for the next window.
      lock_cnt_d = '0;
    end

    // Reads report data; writes report only when they were refused.
    e_rvalid_d = own_e && (!e_we || !legal_e);
    e_err_d    = own_e && !legal_e;
    e_rdata_d  = (own_e && !e_we && legal_e) ? dm_rdata : '0;
  end

  // State registers with synchronous reset; reset also discards a pending response.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wait_cnt_q <= '0;
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
      e_rvalid_q <= 1'b0;
      e_err_q    <= 1'b0;
      e_rdata_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= lock_d;
      e_rvalid_q <= e_rvalid_d;
      e_err_q    <= e_err_d;
      e_rdata_q  <= e_rdata_d;
    end
  end

  assign e_rvalid = e_rvalid_q;
  assign e_err    = e_err_q;
  assign e_rdata  = e_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios followed by
// randomized traffic, compared every cycle against a behavioural model.
module tb_dm_arbiter;

  localparam int          WAIT_MAX = 4;
  localparam int          LOCK_MAX = 8;
  localparam logic [31:0] LIMIT    = 32'h0000_3000;
  localparam logic [31:0] EXT_PC   = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_req, p_we, e_req, e_we, e_lock;
  logic [3:0]  p_mode, e_mode;
  logic [31:0] p_addr, p_wdata, p_pc, e_addr, e_wdata;
  logic [31:0] p_rdata, e_rdata, dm_addr, dm_wdata, dm_pc, dm_rdata;
  logic        p_stall, p_err, e_gnt, e_rvalid, e_err, dm_we;
  logic [3:0]  dm_mode;

  always #5 clk = ~clk;

  dm_arbiter #(
    .WAIT_MAX(WAIT_MAX), .LOCK_MAX(LOCK_MAX), .ADDR_LIMIT(LIMIT), .EXT_PC(EXT_PC)
  ) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_mode(p_mode), .p_addr(p_addr),
    .p_wdata(p_wdata), .p_pc(p_pc), .p_rdata(p_rdata), .p_stall(p_stall), .p_err(p_err),
    .e_req(e_req), .e_we(e_we), .e_mode(e_mode), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_lock(e_lock), .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata), .e_err(e_err),
    .dm_we(dm_we), .dm_mode(dm_mode), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_pc(dm_pc), .dm_rdata(dm_rdata)
  );

  // Data memory stub: word storage, combinational read, write on the clock edge.
  logic [31:0] dm_mem [0:3071] = '{default: 32'h0};
  assign dm_rdata = (dm_addr < LIMIT) ? dm_mem[dm_addr[13:2]] : 32'h0;
  always @(posedge clk) if (dm_we && dm_addr < LIMIT) dm_mem[dm_addr[13:2]] <= dm_wdata;

  // Reference model state.
  logic [31:0] ref_mem [0:3071] = '{default: 32'h0};
  int          m_wait, m_lcnt;
  bit          m_lock;
  bit          exp_rvalid, exp_err;
  logic [31:0] exp_rdata;

  int checks = 0;
  int errors = 0;

  // Values observed in the most recent cycle, for directed expectations.
  bit          obs_gnt, obs_stall, obs_perr, obs_dmwe, obs_rvalid, obs_eerr;
  logic [31:0] obs_erdata, obs_prdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_legal(input logic [3:0] mode, input bit we, input logic [31:0] addr);
    int size;
    if (mode > 4 || addr >= LIMIT) return 1'b0;
    if (we && mode > 2) return 1'b0;
    size = (mode == 0) ? 4 : ((mode == 2 || mode == 4) ? 2 : 1);
    return (addr % size) == 0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return (a < LIMIT) ? ref_mem[a[13:2]] : 32'h0;
  endfunction

  // One clock cycle: check outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    bit          oe, op, le, lp, starve, lok, we_x;
    logic [31:0] a_x, wd_x;
    @(negedge clk); #1;
    le     = ref_legal(e_mode, e_we, e_addr);
    lp     = ref_legal(p_mode, p_we, p_addr);
    starve = (m_wait == WAIT_MAX);
    lok    = m_lock && (m_lcnt < LOCK_MAX);
    oe     = !reset && e_req && (!p_req || starve || lok);
    op     = !reset && p_req && !oe;
    a_x    = oe ? e_addr : p_addr;
    wd_x   = oe ? e_wdata : p_wdata;
    we_x   = (oe && e_we && le) || (op && p_we && lp);

    obs_gnt = e_gnt; obs_stall = p_stall; obs_perr = p_err; obs_dmwe = dm_we;
    obs_rvalid = e_rvalid; obs_eerr = e_err; obs_erdata = e_rdata; obs_prdata = p_rdata;

    chk("e_gnt",    e_gnt,    oe);
    chk("p_stall",  p_stall,  p_req && oe);
    chk("p_err",    p_err,    op && !lp);
    chk("dm_we",    dm_we,    we_x);
    chk("dm_addr",  dm_addr,  a_x);
    chk("dm_wdata", dm_wdata, wd_x);
    chk("dm_mode",  dm_mode,  oe ? e_mode : p_mode);
    chk("dm_pc",    dm_pc,    oe ? EXT_PC : p_pc);
    chk("p_rdata",  p_rdata,  ref_rd(a_x));
    chk("e_rvalid", e_rvalid, exp_rvalid);
    chk("e_err",    e_err,    exp_err);
    chk("e_rdata",  e_rdata,  exp_rdata);

    @(posedge clk);
    if (reset) begin
      exp_rvalid = 0; exp_err = 0; exp_rdata = 0;
      m_wait = 0; m_lock = 0; m_lcnt = 0;
    end else begin
      exp_rvalid = oe && (!e_we || !le);
      exp_err    = oe && !le;
      exp_rdata  = (oe && !e_we && le) ? ref_rd(e_addr) : 32'h0;
      if (we_x) ref_mem[a_x[13:2]] = wd_x;
      if (oe || !e_req) m_wait = 0;
      else if (m_wait < WAIT_MAX) m_wait++;
      if (oe) begin
        m_lock = e_lock;
        if (m_lcnt < LOCK_MAX) m_lcnt++;
      end else if (!e_req) begin
        m_lock = 0; m_lcnt = 0;
      end else if (m_lcnt == LOCK_MAX && p_req) begin
        m_lcnt = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    p_req = 0; p_we = 0; p_mode = 0; p_addr = 0; p_wdata = 0; p_pc = 32'h100;
    e_req = 0; e_we = 0; e_mode = 0; e_addr = 0; e_wdata = 0; e_lock = 0;
  endtask

  initial begin
    bit gq[$];
    int k, first;
    reset = 1; idle();
    m_wait = 0; m_lock = 0; m_lcnt = 0;
    exp_rvalid = 0; exp_err = 0; exp_rdata = 0;

    // Reset: nothing granted, nothing written.
    p_req = 1; p_we = 1; e_req = 1;
    cycle(); cycle();
    chk("rst_gnt", obs_gnt, 0);
    chk("rst_dmwe", obs_dmwe, 0);
    reset = 0; idle();
    cycle();

    // P-only write then read.
    p_req = 1; p_we = 1; p_addr = 32'h10; p_wdata = 32'h1234_5678;
    cycle();
    chk("p_wr_dmwe", obs_dmwe, 1);
    chk("p_wr_stall", obs_stall, 0);
    p_we = 0;
    cycle();
    chk("p_rd_dmwe", obs_dmwe, 0);
    chk("p_rd_data", obs_prdata, 32'h1234_5678);
    p_we = 1; p_addr = 32'h20; p_wdata = 32'hCAFE_F00D;
    cycle();

    // Contention: E read is force-granted on the fifth cycle.
    p_we = 0; p_addr = 32'h10;
    e_req = 1; e_we = 0; e_addr = 32'h20;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk($sformatf("cont_gnt%0d", i), obs_gnt, (i == 4));
      chk($sformatf("cont_stall%0d", i), obs_stall, (i == 4));
    end
    e_req = 0;
    cycle();
    chk("cont_rvalid", obs_rvalid, 1);
    chk("cont_rdata", obs_erdata, 32'hCAFE_F00D);

    // Locked burst of ten E writes against continuous P reads.
    e_req = 1; e_we = 1; e_lock = 1; k = 0;
    for (int c = 0; c < 40 && k < 10; c++) begin
      e_addr = 32'(k * 4); e_wdata = 32'hA000_0000 + 32'(k);
      cycle();
      gq.push_back(obs_gnt);
      if (obs_gnt) k++;
    end
    chk("lock_done", k, 10);
    first = -1;
    foreach (gq[i]) if (first < 0 && gq[i]) first = i;
    if (first >= 0 && gq.size() > first + 9) begin
      k = 0;
      for (int i = 0; i < 8; i++) k += gq[first + i];
      chk("lock_run8", k, 8);
      chk("lock_pgap", gq[first + 8], 0);
      chk("lock_resume", gq[first + 9], 1);
    end else begin
      chk("lock_pattern_len", gq.size(), first + 10);
    end
    e_req = 0; e_lock = 0; p_addr = 32'h24;
    cycle();
    chk("lock_rdback", obs_prdata, 32'hA000_0009);

    // Illegal accesses: E misaligned out-of-range half write, then P word write at the limit.
    p_req = 0; e_req = 1; e_we = 1; e_mode = 2; e_addr = 32'h3001;
    cycle();
    chk("ill_e_dmwe", obs_dmwe, 0);
    chk("ill_e_gnt", obs_gnt, 1);
    e_req = 0; p_req = 1; p_we = 1; p_mode = 0; p_addr = 32'h3000;
    cycle();
    chk("ill_p_dmwe", obs_dmwe, 0);
    chk("ill_p_err", obs_perr, 1);
    chk("ill_e_rvalid", obs_rvalid, 1);
    chk("ill_e_err", obs_eerr, 1);

    // Mode checks: store with an unsigned mode is illegal; half-unsigned load @0x2 is fine.
    p_mode = 3; p_addr = 32'h8;
    cycle();
    chk("mode3_dmwe", obs_dmwe, 0);
    chk("mode3_err", obs_perr, 1);
    p_we = 0; p_mode = 4; p_addr = 32'h2;
    cycle();
    chk("mode4_err", obs_perr, 0);

    // Reset in the middle of a locked E burst.
    idle();
    e_req = 1; e_lock = 1; e_addr = 32'h10;
    cycle(); cycle();
    reset = 1; p_req = 1; p_we = 1; e_we = 1;
    cycle();
    chk("rlock_gnt", obs_gnt, 0);
    chk("rlock_dmwe", obs_dmwe, 0);
    reset = 0; p_we = 0; e_we = 0;
    cycle();
    chk("rlock_pwins_gnt", obs_gnt, 0);
    chk("rlock_pwins_stall", obs_stall, 0);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      reset   = ($urandom_range(0, 79) == 0);
      p_req   = ($urandom_range(0, 2) != 0);
      p_we    = $urandom_range(0, 1);
      p_mode  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      p_addr  = ($urandom_range(0, 15) == 0) ? ($urandom & 32'h3FFF) : {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      p_wdata = $urandom;
      p_pc    = $urandom;
      e_req   = ($urandom_range(0, 3) != 0);
      e_we    = $urandom_range(0, 1);
      e_lock  = ($urandom_range(0, 2) != 0);
      e_mode  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      e_addr  = ($urandom_range(0, 15) == 0) ? ($urandom & 32'h3FFF) : {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      e_wdata = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
